// File: rtl/mlu_ctrl_if.sv
// Multiplier-unit bus: operands and mode out to the MLU, completion and product back.
interface mlu_ctrl_if;
  logic        mlu_start;
  logic        mlu_sign;
  logic [31:0] mlu_op1;
  logic [31:0] mlu_op2;
  logic        mlu_ready;
  logic [63:0] mlu_result;

  modport master (
    output mlu_start, mlu_sign, mlu_op1, mlu_op2,
    input  mlu_ready, mlu_result
  );

  modport slave (
    input  mlu_start, mlu_sign, mlu_op1, mlu_op2,
    output mlu_ready, mlu_result
  );
endinterface

// File: rtl/mlu_ctrl.sv
// Multiply controller: sequences MULT/MULTU through an external multiplier,
// stalls the pipeline while the product is pending and owns the HI/LO registers.
module mlu_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_wdata,
  output logic        stall,
  mlu_ctrl_if.master  mlu,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        done,
  output logic        err
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   op1_q;
  logic [DATA_W-1:0]   op2_q;
  logic                sign_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ok_q;
  logic                start_c;
  logic                accept_c;
  logic                capture_c;
  logic                timeout_c;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and control decode; stall is combinational so the request is held the cycle it arrives.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    start_c   = 1'b0;
    done      = 1'b0;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          accept_c = resetn;
          stall    = resetn;
          state_d  = RUN;
        end
      end
      RUN: begin
        stall   = 1'b1;
        start_c = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (mlu.mlu_ready) begin
          capture_c = 1'b1;
          state_d   = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        done    = ok_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/mode latches and RUN cycle counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op1_q  <= '0;
      op2_q  <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
    end else if (accept_c) begin
      op1_q  <= op_a;
      op2_q  <= op_b;
      sign_q <= req_signed;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // Completion outcome (done pulse qualifier) and sticky watchdog flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ok_q <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (capture_c)      ok_q <= 1'b1;
      else if (timeout_c) ok_q <= 1'b0;
      if (timeout_c)      err  <= 1'b1;
    end
  end

  // HI/LO registers; a product capture overrides MTHI/MTLO in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (capture_c) begin
      hi_o <= mlu.mlu_result[2*DATA_W-1:DATA_W];
      lo_o <= mlu.mlu_result[DATA_W-1:0];
    end else begin
      if (hi_we) hi_o <= hilo_wdata;
      if (lo_we) lo_o <= hilo_wdata;
    end
  end

  assign mlu.mlu_start = start_c;
  assign mlu.mlu_sign  = sign_q;
  assign mlu.mlu_op1   = op1_q;
  assign mlu.mlu_op2   = op2_q;

endmodule

// File: doc/mlu_ctrl.md
MLU_CTRL -- requirements
Module: mlu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid, input, 1: EX-stage multiply instruction present; held until stall low.
REQ-004 SHALL have port req_signed, input, 1: 1 = MULT, 0 = MULTU.
REQ-005 SHALL have ports op_a and op_b, input, 32 each: multiplicand and multiplier.
REQ-006 SHALL have port flush, input, 1: pipeline cancel; aborts any in-flight multiply.
REQ-007 SHALL have ports hi_we, lo_we, input, 1 each, and hilo_wdata, input, 32: MTHI/MTLO write.
REQ-008 SHALL have port stall, output, 1: freezes the pipeline while a multiply is pending.
REQ-009 SHALL have ports mlu_start and mlu_sign, output, 1 each: multiplier start level and signed mode.
REQ-010 SHALL have ports mlu_op1 and mlu_op2, output, 32 each: latched operands.
REQ-011 SHALL have port mlu_ready, input, 1, and mlu_result, input, 64: multiplier completion and product.
REQ-012 SHALL have ports hi_o and lo_o, output, 32 each: architectural HI/LO registers.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on successful HI/LO update.
REQ-014 SHALL have port err, output, 1: sticky watchdog-timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 In IDLE with req_valid=1 and flush=0, SHALL latch op_a, op_b and req_signed, drive stall=1 combinationally, and go to RUN.
REQ-017 SHALL drive mlu_start=1 only in RUN, so mlu_start is low for at least one cycle between consecutive multiplies.
REQ-018 SHALL drive mlu_op1, mlu_op2 and mlu_sign from the latched registers only, held stable throughout RUN.
REQ-019 In RUN, SHALL drive stall=1 and increment a 5-bit cycle counter, which clears on RUN entry.
REQ-020 In RUN, SHALL sample mlu_result in the first cycle mlu_ready=1, write hi_o=[63:32] and lo_o=[31:0] at that edge, and go to DONE; product is valid only in that cycle.
REQ-021 In DONE, SHALL drive stall=0, mlu_start=0 and done=1 for exactly one cycle, ignore req_valid (same instruction retiring), and return to IDLE.
REQ-022 With flush=1 in RUN, SHALL go to IDLE next edge: no HI/LO write, no done, and stall low from the next cycle.
REQ-023 With flush=1 in IDLE, SHALL not accept the request; stall=0.
REQ-024 If the counter reaches 16 in RUN without mlu_ready, SHALL set err=1, skip the HI/LO write and go to DONE with done=0.
REQ-025 SHALL apply hi_we/lo_we writes of hilo_wdata in any state; the REQ-020 product write has priority in the same cycle.
REQ-026 SHALL have end-to-end latency, IDLE accept to done, of (multiplier latency + 2) cycles; nominal multiplier latency is 7.

Reset
REQ-027 While resetn=0, SHALL hold state=IDLE, hi_o=lo_o=0, err=0, counter=0, operand latches=0, and stall=mlu_start=mlu_sign=done=0.
REQ-028 Reset asserted mid-RUN SHALL abort immediately, with no HI/LO write and mlu_start low in the same cycle.

Verification
REQ-029 MULTU op_a=op_b=0xFFFFFFFF with model MLU -> stall high 8 cycles, then done; HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 MULT op_a=0xFFFFFFFD (-3), op_b=5 -> mlu_sign=1; HI=0xFFFFFFFF, LO=0xFFFFFFF1; done for one cycle.
REQ-031 MULT 7x6 with flush on the 3rd RUN cycle -> IDLE next cycle; HI/LO keep prior values; done=0; mlu_start low.
REQ-032 mlu_ready tied 0 -> after 16 RUN cycles err=1, stall drops, HI/LO unchanged; err stays set until reset.
REQ-033 Back-to-back MULTU 2x3 then 4x5 -> mlu_start low for at least 1 cycle between them; final HI=0, LO=20; two done pulses.
REQ-034 hi_we=1 with hilo_wdata=0xA5A5A5A5 in the same cycle as product capture (HI=0) -> hi_o=0; an isolated hi_we later -> hi_o=0xA5A5A5A5.
